// File: rtl/serial_adder_pkg.sv
// Purpose: shared types and defaults for the bit-serial adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// Purpose: one-bit full adder cell driven by the serial adder datapath.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i/b_i/cin_i operand and carry bits in; sum_o/carry_o result bits out.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i ^ cin_i;
  assign carry_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule : full_adder

// File: rtl/serial_adder.sv
// Purpose: WIDTH-bit adder that feeds one LSB-first bit pair per clock through full_adder.
// Latency: out_valid rises WIDTH+1 clocks after the accept clock (accept clock counted); one result per WIDTH+2 clocks.
// Backpressure: in_ready only in IDLE; sum/cout/out_valid held in DONE until out_ready.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/a/b/cin operand handshake;
//        out_valid/out_ready/sum/cout result handshake; busy high while shifting.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  sa_state_t        state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q,  carry_d;

  logic             fa_sum;
  logic             fa_carry;

  full_adder u_fa (
    .a_i     (a_sh_q[0]),
    .b_i     (b_sh_q[0]),
    .cin_i   (carry_q),
    .sum_o   (fa_sum),
    .carry_o (fa_carry)
  );

  // Datapath next-state. Operands drain from the LSB; each new sum bit
  // enters at the MSB so after WIDTH shifts bit 0 sits at sum_sh[0].
  always_comb begin
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = CNT_LOAD;
        end
      end
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_carry;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;  // DONE holds the result stable for the consumer
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
    end
  end

  // Control FSM with registered handshake outputs, updated on the same
  // edge as the state so they always agree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE here means no accept can coincide with the hand-off.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_sh_q;
  assign cout      = carry_q;

endmodule : serial_adder
